junction_phase_scheduler: RTL and testbench
===========================================

Name: junction_phase_scheduler

Overview:
- Demand-actuated phase scheduler for the 4-way junction (directions S, W, N, E).
- Latches vehicle-detector requests and grants green round-robin, skipping approaches with no demand.
- Enforces min/max green, yellow and all-red clearance, and drives the 12 lamp outputs plus a countdown for the 7-segment display path.
- Timing advances only on the 1 Hz `tick` enable. All logic is on the single system clock.

Parameters:
- MIN_GREEN, 5: minimum green length in ticks (>=1).
- MAX_GREEN, 15: maximum green length in ticks when another direction is pending (>=MIN_GREEN).
- YELLOW_TIME, 2: yellow length in ticks (>=1).
- ALL_RED_TIME, 1: all-red clearance length in ticks (>=1).
- CNT_W, 6: width of timing counters and of `countdown`.

Ports:
- clk1  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk1)
- tick  in  1  one-cycle 1 Hz enable pulse from the clock divider
- req  in  4  detector requests, bit0=S, bit1=W, bit2=N, bit3=E; level or pulse
- emerg_req  in  1  emergency preemption request (used only with the optional feature)
- emerg_dir  in  2  direction requested by the emergency (0=S, 1=W, 2=N, 3=E)
- red  out  4  red lamps, one bit per direction
- yellow  out  4  yellow lamps, one bit per direction
- green  out  4  green lamps, one bit per direction
- grant_dir  out  2  direction currently served, or last served when all-red
- phase  out  2  current phase: 0=ALL_RED, 1=GREEN, 2=YELLOW
- countdown  out  CNT_W  ticks remaining in the current interval
- pending  out  4  latched request mask

Behaviour:
- Reset values:
  - phase=ALL_RED, countdown=ALL_RED_TIME, grant_dir=3 (E, so S is first in round-robin).
  - pending=0, red=4'b1111, yellow=0, green=0.
  - Internal extension counter = 0.
- Reset mid-operation (reset=0): every register returns to its reset value on the next clk1 edge, whether or not tick is present.
- Request latching:
  - On any clk1 edge, `pending[i]` is set when req[i]=1.
  - Exception: req[i] for the direction currently in GREEN is not latched; that direction is already being served.
  - pending[i] is cleared on the edge that enters GREEN for direction i. A req[i] in that same cycle is discarded.
- Lamps are combinational from phase and grant_dir. Each direction has exactly one lamp lit:
  - grant_dir gets green or yellow according to phase.
  - All other directions are red.
  - In ALL_RED, all four directions are red.
- Interval timing:
  - Each interval loads its length N on entry.
  - On each tick with countdown>1, countdown decrements.
  - The tick with countdown==1 is the decision or transition point, so an interval lasts exactly N ticks.
  - With tick=0, nothing in the timing path changes.
- ALL_RED, at the decision tick:
  - If pending!=0: pick the next pending direction after grant_dir in order S->W->N->E->S. Enter GREEN for it, countdown=MIN_GREEN, extension counter=0.
  - Otherwise stay in ALL_RED with countdown held at 1 (idle) until a request arrives. The grant happens on the first tick after pending becomes nonzero.
- GREEN, at the decision tick:
  - Let other = pending with the grant_dir bit masked.
  - If other==0: rest on green; countdown stays 1 and the extension counter saturates.
  - Else if req[grant_dir]==1 and MIN_GREEN+extension < MAX_GREEN: extend; extension counter +1, countdown stays 1.
  - Else: enter YELLOW, countdown=YELLOW_TIME.
- YELLOW, at the decision tick: enter ALL_RED, countdown=ALL_RED_TIME.
- Counter widths: all timing counters are CNT_W bits. A parameter value that exceeds 2^CNT_W-1 is a configuration error, flagged by an elaboration-time check.

Optional Feature:
- Macro: JUNCTION_EMERG_PREEMPT_EN.
- When defined, a rising edge of emerg_req is captured. Then:
  - If currently GREEN on emerg_dir: hold green while emerg_req=1, ignoring MAX_GREEN.
  - If GREEN on another direction: enter YELLOW on the next tick, ignoring MIN_GREEN.
  - If YELLOW: finish yellow normally.
  - If ALL_RED: finish the clearance normally.
  - Then grant emerg_dir regardless of round-robin and pending, and hold green while emerg_req=1.
  - When emerg_req deasserts, normal GREEN rules resume with the extension counter treated as saturated.
- When undefined, emerg_req and emerg_dir are ignored and no preemption logic is synthesized.

Decomposition:
- Package junction_pkg holds:
  - Phase codes PH_ALL_RED, PH_GREEN, PH_YELLOW.
  - Direction codes DIR_S=0, DIR_W=1, DIR_N=2, DIR_E=3.
  - Default timing constants.
- One sub-module, rr_arbiter4: combinational next-direction pick from (pending mask, last grant_dir), returning {valid, dir}. Shared with future pedestrian scheduling.

Test Plan:
- Reset, then req=4'b0001 pulsed one cycle: S green on the 1st tick (ALL_RED_TIME=1) and pending=0. With no other requests, S rests green indefinitely with countdown=1.
- req=4'b1111 held: grant order S, W, N, E, S. Each green lasts 15 ticks (extended to MAX_GREEN), yellow 2 ticks, all-red 1 tick, so each cycle is 4×18=72 ticks.
- S green with req[0]=0 and W pending: yellow after exactly 5 ticks, all-red after 2 more, W green after 1 more.
- req[0] asserted in the same cycle S enters GREEN: pending[0] stays 0. The lamp invariant (one lamp per direction) holds on every cycle of a random run.
- Reset driven low mid-YELLOW with tick=0: next edge gives red=4'b1111, phase=0, countdown=1, pending=0.
- With JUNCTION_EMERG_PREEMPT_EN, during S green at tick 2, emerg_req=1 with emerg_dir=2: S yellow on the next tick, then all-red, then N green held until emerg_req=0.

Source files
------------

// File: rtl/junction_pkg.sv
// junction_pkg: shared codes and defaults for the junction phase scheduler.
//   phase_e : PH_ALL_RED / PH_GREEN / PH_YELLOW (also the encoding of `phase`)
//   dir_e   : DIR_S=0, DIR_W=1, DIR_N=2, DIR_E=3 (bit index into lamp/req masks)
//   DEF_*   : default timing in 1 Hz ticks
package junction_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        DIR_S = 2'd0,
        DIR_W = 2'd1,
        DIR_N = 2'd2,
        DIR_E = 2'd3
    } dir_e;

    localparam int DEF_MIN_GREEN    = 5;
    localparam int DEF_MAX_GREEN    = 15;
    localparam int DEF_YELLOW_TIME  = 2;
    localparam int DEF_ALL_RED_TIME = 1;
    localparam int DEF_CNT_W        = 6;

    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/junction_phase_scheduler_if.sv
// junction_phase_scheduler_if: bundles the detector/emergency inputs and the
// lamp/status outputs of the scheduler.
//   master : controller side (drives tick, req, emerg_*; observes outputs)
//   slave  : scheduler side
interface junction_phase_scheduler_if #(
    parameter int CNT_W = 6
);
    logic             tick;
    logic [3:0]       req;
    logic             emerg_req;
    logic [1:0]       emerg_dir;
    logic [3:0]       red;
    logic [3:0]       yellow;
    logic [3:0]       green;
    logic [1:0]       grant_dir;
    logic [1:0]       phase;
    logic [CNT_W-1:0] countdown;
    logic [3:0]       pending;

    modport master (
        output tick, req, emerg_req, emerg_dir,
        input  red, yellow, green, grant_dir, phase, countdown, pending
    );

    modport slave (
        input  tick, req, emerg_req, emerg_dir,
        output red, yellow, green, grant_dir, phase, countdown, pending
    );
endinterface

// File: rtl/junction_phase_scheduler_rr_arbiter4.sv
// rr_arbiter4: combinational round-robin pick over four directions.
//   pend_i  : request mask (bit i = direction i)
//   last_i  : most recently served direction; search starts just after it
//   valid_o : some request present
//   dir_o   : chosen direction (last_i when nothing is pending)
module rr_arbiter4 (
    input  logic [3:0] pend_i,
    input  logic [1:0] last_i,
    output logic       valid_o,
    output logic [1:0] dir_o
);
    always_comb begin
        logic [1:0] cand;
        valid_o = 1'b0;
        dir_o   = last_i;
        // Walk from farthest to nearest so the nearest hit is the one kept;
        // offset 4 wraps back to last_i itself (it is lowest priority).
        for (int k = 4; k >= 1; k--) begin
            cand = last_i + 2'(k);
            if (pend_i[cand]) begin
                valid_o = 1'b1;
                dir_o   = cand;
            end
        end
    end
endmodule

// File: rtl/junction_phase_scheduler.sv
// junction_phase_scheduler: demand-actuated 4-way phase scheduler.
//   clk1   : system clock
//   reset  : synchronous, active-low
//   bus    : slave modport -- tick/req/emerg_* in; lamps, grant_dir, phase,
//            countdown, pending out
// Optional emergency preemption is compiled in with JUNCTION_EMERG_PREEMPT_EN;
// without it emerg_req/emerg_dir are ignored.
module junction_phase_scheduler
    import junction_pkg::*;
#(
    parameter int MIN_GREEN    = DEF_MIN_GREEN,
    parameter int MAX_GREEN    = DEF_MAX_GREEN,
    parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME = DEF_ALL_RED_TIME,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk1,
    input  logic reset,
    junction_phase_scheduler_if.slave bus
);
    localparam int CMAX = (1 << CNT_W) - 1;

    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || YELLOW_TIME < 1 || ALL_RED_TIME < 1 ||
        MIN_GREEN > CMAX || MAX_GREEN > CMAX || YELLOW_TIME > CMAX || ALL_RED_TIME > CMAX)
    begin : g_cfg_err
        $error("junction_phase_scheduler: timing parameters out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] T_MIN   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] T_YEL   = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] T_AR    = CNT_W'(ALL_RED_TIME);
    // ext < EXT_MAX is the same test as MIN_GREEN + ext < MAX_GREEN.
    localparam logic [CNT_W-1:0] EXT_MAX = CNT_W'(MAX_GREEN - MIN_GREEN);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ext_q, ext_d;
    logic [1:0]       dir_q, dir_d;
    logic [3:0]       pend_q, pend_d;

    logic             arb_vld;
    logic [1:0]       arb_dir;
    logic [3:0]       grn_mask;

    rr_arbiter4 u_arb (
        .pend_i  (pend_q),
        .last_i  (dir_q),
        .valid_o (arb_vld),
        .dir_o   (arb_dir)
    );

    assign grn_mask = (phase_q == PH_GREEN) ? dir_onehot(dir_q) : 4'b0000;

`ifdef JUNCTION_EMERG_PREEMPT_EN
    logic em_act_q, em_act_d;
    logic em_prev_q;
`else
    logic unused_emerg;
    assign unused_emerg = ^{bus.emerg_req, bus.emerg_dir};
`endif

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        ext_d   = ext_q;
        dir_d   = dir_q;
        // The direction being served does not re-latch its own request.
        pend_d  = pend_q | (bus.req & ~grn_mask);

        if (bus.tick) begin
            if (cnt_q > ONE) begin
                cnt_d = cnt_q - ONE;
            end else begin
                unique case (phase_q)
                    PH_ALL_RED: begin
                        if (arb_vld) begin
                            phase_d         = PH_GREEN;
                            dir_d           = arb_dir;
                            cnt_d           = T_MIN;
                            ext_d           = '0;
                            pend_d[arb_dir] = 1'b0;
                        end
                    end
                    PH_GREEN: begin
                        if ((pend_q & ~grn_mask) == 4'b0000) begin
                            if (ext_q < EXT_MAX) ext_d = ext_q + ONE;
                        end else if (bus.req[dir_q] && ext_q < EXT_MAX) begin
                            ext_d = ext_q + ONE;
                        end else begin
                            phase_d = PH_YELLOW;
                            cnt_d   = T_YEL;
                        end
                    end
                    PH_YELLOW: begin
                        phase_d = PH_ALL_RED;
                        cnt_d   = T_AR;
                    end
                    default: begin
                        phase_d = PH_ALL_RED;
                        cnt_d   = T_AR;
                    end
                endcase
            end
        end

`ifdef JUNCTION_EMERG_PREEMPT_EN
        // Capture a rising edge; drop the preemption once the request goes away.
        em_act_d = (em_act_q | (bus.emerg_req & ~em_prev_q)) & bus.emerg_req;
        if (em_act_q && !bus.emerg_req && phase_q == PH_GREEN && dir_q == bus.emerg_dir)
            ext_d = EXT_MAX;
        if (em_act_q && bus.emerg_req && bus.tick) begin
            if (phase_q == PH_GREEN && dir_q == bus.emerg_dir) begin
                if (cnt_q <= ONE) begin
                    phase_d = PH_GREEN;
                    cnt_d   = ONE;
                    ext_d   = EXT_MAX;
                end
            end else if (phase_q == PH_GREEN) begin
                phase_d = PH_YELLOW;
                cnt_d   = T_YEL;
            end else if (phase_q == PH_ALL_RED && cnt_q <= ONE) begin
                phase_d = PH_GREEN;
                dir_d   = bus.emerg_dir;
                cnt_d   = T_MIN;
                ext_d   = '0;
                pend_d  = pend_q | (bus.req & ~grn_mask);
                pend_d[bus.emerg_dir] = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk1) begin
        if (!reset) begin
            phase_q <= PH_ALL_RED;
            cnt_q   <= T_AR;
            ext_q   <= '0;
            dir_q   <= DIR_E;
            pend_q  <= 4'b0000;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ext_q   <= ext_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
        end
    end

`ifdef JUNCTION_EMERG_PREEMPT_EN
    always_ff @(posedge clk1) begin
        if (!reset) begin
            em_act_q  <= 1'b0;
            em_prev_q <= 1'b0;
        end else begin
            em_act_q  <= em_act_d;
            em_prev_q <= bus.emerg_req;
        end
    end
`endif

    assign bus.green     = (phase_q == PH_GREEN)  ? dir_onehot(dir_q) : 4'b0000;
    assign bus.yellow    = (phase_q == PH_YELLOW) ? dir_onehot(dir_q) : 4'b0000;
    assign bus.red       = ~(bus.green | bus.yellow);
    assign bus.grant_dir = dir_q;
    assign bus.phase     = phase_q;
    assign bus.countdown = cnt_q;
    assign bus.pending   = pend_q;
endmodule

// File: tb/tb_junction_phase_scheduler.sv
// tb_junction_phase_scheduler: directed + random check of the default build
// (MIN_GREEN=5, MAX_GREEN=15, YELLOW_TIME=2, ALL_RED_TIME=1, CNT_W=6).
module tb_junction_phase_scheduler;
    localparam int CNT_W = 6;

    logic clk1  = 1'b0;
    logic reset = 1'b0;
    always #5 clk1 = ~clk1;

    junction_phase_scheduler_if #(.CNT_W(CNT_W)) bus ();

    junction_phase_scheduler #(
        .MIN_GREEN(5), .MAX_GREEN(15), .YELLOW_TIME(2), .ALL_RED_TIME(1), .CNT_W(CNT_W)
    ) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_fail = 0;

    task automatic push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.v   = 32'(v);
        sb.push_back(e);
    endtask

    // Expected state straight from the lamp rules: grant_dir lit green or
    // yellow by phase, every other direction red.
    task automatic push_state(input string tag, input int ph, input int gd, input int cd, input int pd);
        int g, y;
        g = (ph == 1) ? (1 << gd) : 0;
        y = (ph == 2) ? (1 << gd) : 0;
        push({tag, ".phase"}, ph);
        push({tag, ".grant"}, gd);
        push({tag, ".countdown"}, cd);
        push({tag, ".pending"}, pd);
        push({tag, ".red"}, (~(g | y)) & 15);
        push({tag, ".yellow"}, y);
        push({tag, ".green"}, g);
    endtask

    task automatic pop_one(input logic [31:0] obs);
        exp_t e;
        n_tot++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.v);
        end
    endtask

    task automatic pop_state();
        pop_one(32'(bus.phase));
        pop_one(32'(bus.grant_dir));
        pop_one(32'(bus.countdown));
        pop_one(32'(bus.pending));
        pop_one(32'(bus.red));
        pop_one(32'(bus.yellow));
        pop_one(32'(bus.green));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input logic tk);
        bus.tick = tk;
        @(negedge clk1);
        bus.tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        bus.req = 4'b0000;
        step(1'b0);
        step(1'b0);
        reset = 1'b1;
    endtask

    initial begin
        bus.tick      = 1'b0;
        bus.req       = 4'b0000;
        bus.emerg_req = 1'b0;
        bus.emerg_dir = 2'd0;
        @(negedge clk1);

        // Reset state.
        do_reset();
        push_state("rst", 0, 3, 1, 0);
        pop_state();

        // S pulse: latched, granted on first tick; req[0] on the grant edge
        // and during green is discarded; S then rests on green.
        bus.req = 4'b0001;
        push_state("s_latch", 0, 3, 1, 1);
        step(1'b0);
        pop_state();
        push_state("s_grant", 1, 0, 5, 0);
        step(1'b1);
        pop_state();
        push_state("s_nolatch", 1, 0, 2, 0);
        ticks(3);
        pop_state();
        bus.req = 4'b0000;
        push_state("s_rest", 1, 0, 1, 0);
        ticks(12);
        pop_state();

        // S green with W pending and no S demand: min green, yellow, all-red, W.
        do_reset();
        bus.req = 4'b0011;
        step(1'b0);
        bus.req = 4'b0000;
        push_state("t3_grant", 1, 0, 5, 2);
        step(1'b1);
        pop_state();
        push_state("t3_min", 1, 0, 1, 2);
        ticks(4);
        pop_state();
        push_state("t3_yel", 2, 0, 2, 2);
        step(1'b1);
        pop_state();
        push_state("t3_yel1", 2, 0, 1, 2);
        step(1'b1);
        pop_state();
        push_state("t3_ar", 0, 0, 1, 2);
        step(1'b1);
        pop_state();
        push_state("t3_w", 1, 1, 5, 0);
        step(1'b1);
        pop_state();

        // Drive W into yellow, then reset mid-yellow with tick low.
        bus.req = 4'b0001;
        step(1'b0);
        bus.req = 4'b0000;
        push_state("t4_yel", 2, 1, 2, 1);
        ticks(5);
        pop_state();
        reset = 1'b0;
        push_state("t4_rst", 0, 3, 1, 0);
        step(1'b0);
        pop_state();
        reset = 1'b1;

        // All requests held: S, W, N, E, S, each green extended to MAX_GREEN.
        bus.req = 4'b1111;
        step(1'b0);
        for (int k = 0; k < 4; k++) begin
            push_state($sformatf("rr%0d_grant", k), 1, k, 5, 15 & ~(1 << k));
            step(1'b1);
            pop_state();
            push_state($sformatf("rr%0d_ext", k), 1, k, 1, 15 & ~(1 << k));
            ticks(14);
            pop_state();
            push_state($sformatf("rr%0d_yel", k), 2, k, 2, 15 & ~(1 << k));
            step(1'b1);
            pop_state();
            push_state($sformatf("rr%0d_ar", k), 0, k, 1, 15);
            ticks(2);
            pop_state();
        end
        push_state("rr4_grant", 1, 0, 5, 14);
        step(1'b1);
        pop_state();

        // Random traffic: one lamp per direction, consistent with phase/grant.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] g, y;
            bus.req = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            step($urandom_range(0, 3) == 0);
            g = (bus.phase == 2'd1) ? (4'b0001 << bus.grant_dir) : 4'b0000;
            y = (bus.phase == 2'd2) ? (4'b0001 << bus.grant_dir) : 4'b0000;
            push("rand.lamps", int'({~(g | y), y, g}));
            push("rand.onehot", 1);
            pop_one(32'({bus.red, bus.yellow, bus.green}));
            pop_one(32'(((bus.red ^ bus.yellow ^ bus.green) == 4'hF) &&
                        ((bus.red & bus.yellow) == 0) && ((bus.red & bus.green) == 0) &&
                        ((bus.yellow & bus.green) == 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
